// File: rtl/vga_scanout.sv
// vga_scanout
// -----------------------------------------------------------------------------
// Scan-out stage between the 12-bit RGB frame-buffer RAM and the VGA connector.
// Free-running h/v counters generate the raster and the RAM read address. The
// RAM's one-cycle read latency is matched by a stage-1 register of the decoded
// timing flags. Stage 2 registers the pixel colour and the active-low syncs, so
// every output is exactly two cycles behind the counters. While the raster is
// outside the visible area, an upstream writer may take the RAM port through a
// combinational req/ack handshake.
//
// Ports
//   clk_d        pixel clock, shared with the RAM
//   rst_n        synchronous active-low reset
//   ram_addr     RAM address: scan address, or wr_addr on an accepted write
//   ram_din      RAM write data (always wr_data)
//   ram_we       RAM write enable (high only on an accepted write)
//   ram_dout     RAM registered read data
//   wr_req       upstream write request, held until wr_ack
//   wr_addr      upstream write address
//   wr_data      upstream write data
//   wr_ack       write accepted this cycle (combinational)
//   red/green/blue  4-bit pixel colour, zero outside the visible area
//   hsync/vsync  active-low syncs, aligned with the pixel data
//   frame_start  one-cycle pulse coincident with pixel (0,0) on the outputs
// -----------------------------------------------------------------------------
module vga_scanout #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int A      = 20,
  parameter int D      = 12
) (
  input  logic         clk_d,
  input  logic         rst_n,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_din,
  output logic         ram_we,
  input  logic [D-1:0] ram_dout,
  input  logic         wr_req,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  output logic         wr_ack,
  output logic [3:0]   red,
  output logic [3:0]   green,
  output logic [3:0]   blue,
  output logic         hsync,
  output logic         vsync,
  output logic         frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [9:0] h_reg, v_reg;
  logic [9:0] h_next, v_next;

  always_comb begin
    h_next = h_reg + 10'd1;
    v_next = v_reg;
    if (h_reg == H_LAST) begin
      h_next = '0;
      v_next = (v_reg == V_LAST) ? '0 : v_reg + 10'd1;
    end
  end

  always_ff @(posedge clk_d) begin
    if (!rst_n) begin
      h_reg <= '0;
      v_reg <= '0;
    end else begin
      h_reg <= h_next;
      v_reg <= v_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage-0 decode
  // ---------------------------------------------------------------------------
  logic vis0, hs0, vs0, fs0;

  assign vis0 = (h_reg < H_VIS_W) && (v_reg < V_VIS_W);
  assign hs0  = (h_reg >= HS_FIRST) && (h_reg <= HS_LAST);
  assign vs0  = (v_reg >= VS_FIRST) && (v_reg <= VS_LAST);
  assign fs0  = (h_reg == 10'd0) && (v_reg == 10'd0);

  // ---------------------------------------------------------------------------
  // RAM port mux: the scan owns the port during visible pixels; otherwise a
  // pending write request takes it for the cycle. Reset blocks writes so a
  // request asserted during reset cannot corrupt the frame buffer.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ack   = 1'b0;
    ram_addr = A'({h_reg, v_reg});
    if (rst_n && !vis0 && wr_req) begin
      wr_ack   = 1'b1;
      ram_addr = wr_addr;
    end
  end

  assign ram_we  = wr_ack;
  assign ram_din = wr_data;

  // ---------------------------------------------------------------------------
  // Stage 1: timing flags wait alongside the RAM read
  // ---------------------------------------------------------------------------
  logic vis1_reg, hs1_reg, vs1_reg, fs1_reg;

  always_ff @(posedge clk_d) begin
    if (!rst_n) begin
      vis1_reg <= 1'b0;
      hs1_reg  <= 1'b0;
      vs1_reg  <= 1'b0;
      fs1_reg  <= 1'b0;
    end else begin
      vis1_reg <= vis0;
      hs1_reg  <= hs0;
      vs1_reg  <= vs0;
      fs1_reg  <= fs0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: registered outputs. Reads issued during blanking return whatever
  // the RAM last held (or a just-written word), so they are masked here.
  // ---------------------------------------------------------------------------
  logic [11:0] pix_reg;
  logic        hsync_reg, vsync_reg, fs2_reg;

  always_ff @(posedge clk_d) begin
    if (!rst_n) begin
      pix_reg   <= '0;
      hsync_reg <= 1'b1;
      vsync_reg <= 1'b1;
      fs2_reg   <= 1'b0;
    end else begin
      pix_reg   <= vis1_reg ? ram_dout[11:0] : 12'h000;
      hsync_reg <= ~hs1_reg;
      vsync_reg <= ~vs1_reg;
      fs2_reg   <= fs1_reg;
    end
  end

  assign red         = pix_reg[11:8];
  assign green       = pix_reg[7:4];
  assign blue        = pix_reg[3:0];
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign frame_start = fs2_reg;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout
// -----------------------------------------------------------------------------
// Bench for vga_scanout using a reduced raster so several frames fit in a short
// run: 16+4+6+6 = 32 clocks per line, 12+3+2+4 = 21 lines, 672 clocks per
// frame. Sync window h in [20,25], v in [15,16].
//
// k counts clock edges taken with rst_n high since the last reset edge, so the
// counters hold position k mod 672 and the outputs show position k-2.
// Expected events (frame_start, sync edges and widths, write acks, pixel values)
// are queued by the stimulus process; a negedge monitor pops and compares them
// as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_vga_scanout;

  localparam int H_VIS  = 16;
  localparam int H_FP   = 4;
  localparam int H_SYNC = 6;
  localparam int H_BP   = 6;
  localparam int V_VIS  = 12;
  localparam int V_FP   = 3;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 4;
  localparam int FRAME  = 672;

  logic        clk;
  logic        rst_n;
  logic [19:0] ram_addr;
  logic [11:0] ram_din;
  logic        ram_we;
  logic [11:0] ram_dout;
  logic        wr_req;
  logic [19:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ack;
  logic [3:0]  red, green, blue;
  logic        hsync, vsync, frame_start;

  vga_scanout #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .A(20), .D(12)
  ) dut (
    .clk_d      (clk),
    .rst_n      (rst_n),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .hsync      (hsync),
    .vsync      (vsync),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Frame-buffer RAM model (registered read) and cycle bookkeeping
  // ---------------------------------------------------------------------------
  logic [11:0] mem [0:1048575];
  int   cyc      = 0;
  int   k        = 0;
  logic rst_edge = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    k        <= (rst_n === 1'b1) ? k + 1 : 0;
    rst_edge <= (rst_n !== 1'b1);
    if (cyc == 0) begin
      mem[{10'd0,  10'd0}]  <= 12'hABC;
      mem[{10'd20, 10'd0}]  <= 12'hFFF;
      mem[{10'd15, 10'd11}] <= 12'h5A5;
      mem[{10'd16, 10'd11}] <= 12'hEEE;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  // ---------------------------------------------------------------------------
  // Scoreboard queues
  // ---------------------------------------------------------------------------
  typedef struct { int k; int w; }              pulse_t;
  typedef struct { int k; int addr; int data; } ack_t;
  typedef struct { int k; int rgb; }            pix_t;

  int     fs_q[$];
  pulse_t hs_q[$];
  pulse_t vs_q[$];
  ack_t   ack_q[$];
  pix_t   pix_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (k=%0d)", name, act, exp, k);
    end else begin
      $display("ok   %s = 0x%0h (k=%0d)", name, act, k);
    end
  endtask

  task automatic extra(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event at k=%0d, required none", name, k);
  endtask

  task automatic push_hs(input int kk, input int w);
    pulse_t p;
    p.k = kk; p.w = w;
    hs_q.push_back(p);
  endtask

  task automatic push_vs(input int kk, input int w);
    pulse_t p;
    p.k = kk; p.w = w;
    vs_q.push_back(p);
  endtask

  task automatic push_ack(input int kk, input int addr, input int data);
    ack_t a;
    a.k = kk; a.addr = addr; a.data = data;
    ack_q.push_back(a);
  endtask

  task automatic push_pix(input int kk, input int rgb);
    pix_t p;
    p.k = kk; p.rgb = rgb;
    pix_q.push_back(p);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic armed   = 1'b0;
  logic hs_prev = 1'b1;
  logic vs_prev = 1'b1;
  logic hs_pend = 1'b0;
  logic vs_pend = 1'b0;
  int   hs_fall_cyc = 0, vs_fall_cyc = 0;
  int   hs_w = 0, vs_w = 0;

  always @(negedge clk) begin : monitor
    pulse_t pl;
    ack_t   ac;
    pix_t   px;
    if (rst_n !== 1'b1)
      chk("reset_wr_port", 32'({ram_we, wr_ack}), 32'd0);
    if (rst_edge) begin
      chk("reset_outputs", 32'({red, green, blue, hsync, vsync, frame_start}), 32'h6);
    end else if (armed) begin
      if (frame_start === 1'b1) begin
        if (fs_q.size() == 0) extra("frame_start");
        else chk("frame_start_k", 32'(k), 32'(fs_q.pop_front()));
      end
      if (pix_q.size() > 0 && pix_q[0].k == k) begin
        px = pix_q.pop_front();
        chk($sformatf("pixel_at_k%0d", k), 32'({red, green, blue}), 32'(px.rgb));
      end
      if (ram_we === 1'b1 || wr_ack === 1'b1) begin
        if (ack_q.size() == 0) extra("wr_ack");
        else begin
          ac = ack_q.pop_front();
          chk("ack_k",    32'(k),        32'(ac.k));
          chk("ack_addr", 32'(ram_addr), 32'(ac.addr));
          chk("ack_data", 32'(ram_din),  32'(ac.data));
          chk("ack_we",   32'({ram_we, wr_ack}), 32'd3);
        end
      end
    end
    if (armed) begin
      if (hs_prev === 1'b1 && hsync === 1'b0) begin
        if (hs_q.size() == 0) extra("hsync_fall");
        else begin
          pl = hs_q.pop_front();
          chk("hsync_fall_k", 32'(k), 32'(pl.k));
          hs_w        <= pl.w;
          hs_fall_cyc <= cyc;
          hs_pend     <= 1'b1;
        end
      end
      if (hs_prev === 1'b0 && hsync === 1'b1 && hs_pend) begin
        chk("hsync_low_cycles", 32'(cyc - hs_fall_cyc), 32'(hs_w));
        hs_pend <= 1'b0;
      end
      if (vs_prev === 1'b1 && vsync === 1'b0) begin
        if (vs_q.size() == 0) extra("vsync_fall");
        else begin
          pl = vs_q.pop_front();
          chk("vsync_fall_k", 32'(k), 32'(pl.k));
          vs_w        <= pl.w;
          vs_fall_cyc <= cyc;
          vs_pend     <= 1'b1;
        end
      end
      if (vs_prev === 1'b0 && vsync === 1'b1 && vs_pend) begin
        chk("vsync_low_cycles", 32'(cyc - vs_fall_cyc), 32'(vs_w));
        vs_pend <= 1'b0;
      end
    end
    hs_prev <= hsync;
    vs_prev <= vsync;
    if (rst_edge) armed <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Stimulus (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic wait_k(input int target);
    int n;
    n = 0;
    while (k != target && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (k != target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_k: k=%0d, required %0d", k, target);
    end
  endtask

  logic acked;
  int   bi;

  initial begin
    rst_n   = 1'b0;
    wr_req  = 1'b1;
    wr_addr = 20'h12345;
    wr_data = 12'h777;

    // Reset held 5 cycles with a write request pending.
    repeat (5) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    wr_req = 1'b0;

    // Frame starts and pixels, hand-computed for the reduced raster.
    fs_q.push_back(2);
    fs_q.push_back(2 + FRAME);
    fs_q.push_back(2 + 2 * FRAME);
    push_pix(2,    12'hABC);  // (0,0) frame 0
    push_pix(22,   12'h000);  // (20,0) blank, RAM holds FFF
    push_pix(369,  12'h5A5);  // (15,11) last visible pixel
    push_pix(370,  12'h000);  // (16,11) first blank pixel, RAM holds EEE
    push_pix(674,  12'hABC);  // (0,0) frame 1
    push_pix(676,  12'h200);  // (2,0) burst write 0
    push_pix(772,  12'h203);  // (2,3) burst write 3
    push_pix(903,  12'h123);  // (5,7) stalled write
    push_pix(1028, 12'h20B);  // (2,11) burst write 11

    // hsync falls at k = frame*672 + line*32 + 22, low 6 cycles; frame 2 is cut
    // by the reset at line 15, one cycle after that line's sync begins.
    for (int f = 0; f < 3; f++) begin
      for (int v = 0; v < 21; v++) begin
        if (f == 2 && v > 15) break;
        push_hs(f * FRAME + v * 32 + 22, (f == 2 && v == 15) ? 1 : 6);
      end
    end
    push_vs(482, 64);
    push_vs(482 + FRAME, 64);
    push_vs(482 + 2 * FRAME, 21);

    // Write stall: request at h=10, v=3; first blank cycle is h=16 (k=112).
    wait_k(106);
    wr_addr = {10'd5, 10'd7};
    wr_data = 12'h123;
    wr_req  = 1'b1;
    push_ack(112, {10'd5, 10'd7}, 12'h123);
    #1;
    for (int n = 0; n < 100 && wr_ack !== 1'b1; n++) begin
      @(posedge clk); #2;
    end
    @(posedge clk); #1;
    wr_req = 1'b0;

    // Burst: request held from h=8 of line 4 until h=4 of line 5; one ack per
    // blank cycle k=144..159, address/data advance after each ack.
    wait_k(136);
    bi      = 0;
    wr_addr = {10'd2, 10'd0};
    wr_data = 12'h200;
    wr_req  = 1'b1;
    for (int i = 0; i < 16; i++)
      push_ack(144 + i, {10'd2, 10'(i)}, 12'h200 + 12'(i));
    for (int c = 0; c < 28; c++) begin
      #1;
      acked = (wr_ack === 1'b1);
      @(posedge clk); #1;
      if (acked) begin
        bi++;
        wr_addr = {10'd2, 10'(bi)};
        wr_data = 12'h200 + 12'(bi);
      end
    end
    wr_req = 1'b0;

    // Mid-frame reset in frame 2 at h=22, v=15 (inside both sync pulses).
    wait_k(2 * FRAME + 15 * 32 + 22);
    rst_n = 1'b0;
    fs_q.push_back(2);
    push_hs(22, 6);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_k(40);
    repeat (3) @(posedge clk);
    #1;

    while (fs_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_start_missing: not observed, required at k=%0d", fs_q.pop_front());
    end
    while (hs_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL hsync_fall_missing: not observed, required at k=%0d", hs_q.pop_front().k);
    end
    while (vs_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL vsync_fall_missing: not observed, required at k=%0d", vs_q.pop_front().k);
    end
    while (ack_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL wr_ack_missing: not observed, required at k=%0d", ack_q.pop_front().k);
    end
    while (pix_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL pixel_missing: not checked, required at k=%0d", pix_q.pop_front().k);
    end
    if (hs_pend || vs_pend) begin
      n_cmp++; n_bad++;
      $display("FAIL sync_release: sync still low at end, required high");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
